parity_stream_checker: RTL and testbench

- Parametrised successor to the team's 4-bit combinational even-parity block.
- Checks a stream of WIDTH-bit words. Each word carries one row-parity bit.
- Groups words into frames of FRAME_LEN beats. The last beat of each frame is an LRC word (column parity) over the preceding data words.
- Selectable even/odd mode, valid/ready handshake on both sides, registered single-stage pipeline, saturating frame-error counter.
- Sits between a serial/byte receiver and downstream consumers.

---
 rtl/parity_stream_checker.sv | 116 +++++++++++
 tb/tb_parity_stream_checker.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/parity_stream_checker.sv
// Row/column (LRC) parity checker for a framed word stream with valid/ready
// handshakes, a single registered output stage and a saturating frame-error counter.
module parity_stream_checker #(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 4,
   parameter int CNT_W     = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_odd_mode,
   input  logic             i_clear,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_in_data,
   input  logic             i_in_par,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_out_data,
   output logic             o_word_err,
   output logic             o_frame_last,
   output logic             o_frame_err,
   output logic [CNT_W-1:0] o_err_count
);

   localparam int IDX_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic             r_outValid;
   logic [WIDTH-1:0] r_outData;
   logic             r_wordErr;
   logic             r_frameLast;
   logic             r_frameErr;
   logic [CNT_W-1:0] r_errCount;
   logic [IDX_W-1:0] r_beatIdx;
   logic [WIDTH-1:0] r_acc;
   logic             r_sticky;
   logic             r_mode;

   logic             w_accept;
   logic [IDX_W-1:0] w_idx;
   logic [WIDTH-1:0] w_acc;
   logic             w_sticky;
   logic             w_mode;
   logic             w_isLast;
   logic             w_rowErr;
   logic [WIDTH-1:0] w_lrcExp;
   logic             w_lrcErr;
   logic             w_frameErr;

   assign o_in_ready = !r_outValid || i_out_ready;
   assign w_accept   = i_in_valid && o_in_ready;

   // A same-cycle clear makes the incoming word beat 0 of a fresh frame.
   assign w_idx      = i_clear ? '0   : r_beatIdx;
   assign w_acc      = i_clear ? '0   : r_acc;
   assign w_sticky   = i_clear ? 1'b0 : r_sticky;
   assign w_mode     = (w_idx == '0) ? i_odd_mode : r_mode;

   assign w_isLast   = (w_idx == LAST_IDX);
   assign w_rowErr   = i_in_par != ((^i_in_data) ^ w_mode);
   assign w_lrcExp   = w_mode ? ~w_acc : w_acc;
   assign w_lrcErr   = w_isLast && (i_in_data != w_lrcExp);
   assign w_frameErr = w_isLast && (w_lrcErr || w_rowErr || w_sticky);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_outValid  <= 1'b0;
         r_outData   <= '0;
         r_wordErr   <= 1'b0;
         r_frameLast <= 1'b0;
         r_frameErr  <= 1'b0;
         r_errCount  <= '0;
         r_beatIdx   <= '0;
         r_acc       <= '0;
         r_sticky    <= 1'b0;
         r_mode      <= 1'b0;
      end else if (w_accept) begin
         r_outValid  <= 1'b1;
         r_outData   <= i_in_data;
         r_wordErr   <= w_rowErr;
         r_frameLast <= w_isLast;
         r_frameErr  <= w_frameErr;
         r_mode      <= w_mode;
         if (w_isLast) begin
            r_beatIdx <= '0;
            r_acc     <= '0;
            r_sticky  <= 1'b0;
            if (w_frameErr && (r_errCount != CNT_MAX)) begin
               r_errCount <= r_errCount + 1'b1;
            end
         end else begin
            r_beatIdx <= w_idx + 1'b1;
            r_acc     <= w_acc ^ i_in_data;
            r_sticky  <= w_sticky | w_rowErr;
         end
      end else begin
         if (r_outValid && i_out_ready) begin
            r_outValid <= 1'b0;
         end
         if (i_clear) begin
            r_beatIdx <= '0;
            r_acc     <= '0;
            r_sticky  <= 1'b0;
         end
      end
   end

   assign o_out_valid  = r_outValid;
   assign o_out_data   = r_outData;
   assign o_word_err   = r_wordErr;
   assign o_frame_last = r_frameLast;
   assign o_frame_err  = r_frameErr;
   assign o_err_count  = r_errCount;

endmodule

// File: tb/tb_parity_stream_checker.sv
// Directed bench for parity_stream_checker: a vector table for whole frames plus
// hand sequences for backpressure, clear, reset and counter saturation.
module tb_parity_stream_checker;

   logic       clk;
   logic       rstN;
   logic       oddMode;
   logic       clearIn;
   logic       inValid;
   logic [7:0] inData;
   logic       inPar;
   logic       outReady;

   logic       inReady, outValid, wordErr, frameLast, frameErr;
   logic [7:0] outData, errCount;
   logic       satInReady, satOutValid, satWordErr, satFrameLast, satFrameErr;
   logic [7:0] satOutData;
   logic [1:0] satCount;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       odd;
      logic       expWordErr;
      logic       expLast;
      logic       expFrameErr;
      int         expCount;
   } vec_t;

   vec_t vecs[16];

   parity_stream_checker #(.WIDTH(8), .FRAME_LEN(4), .CNT_W(8)) dut (
      .i_clk(clk), .i_rst_n(rstN), .i_odd_mode(oddMode), .i_clear(clearIn),
      .i_in_valid(inValid), .o_in_ready(inReady), .i_in_data(inData), .i_in_par(inPar),
      .o_out_valid(outValid), .i_out_ready(outReady), .o_out_data(outData),
      .o_word_err(wordErr), .o_frame_last(frameLast), .o_frame_err(frameErr),
      .o_err_count(errCount)
   );

   parity_stream_checker #(.WIDTH(8), .FRAME_LEN(4), .CNT_W(2)) dutSat (
      .i_clk(clk), .i_rst_n(rstN), .i_odd_mode(oddMode), .i_clear(clearIn),
      .i_in_valid(inValid), .o_in_ready(satInReady), .i_in_data(inData), .i_in_par(inPar),
      .o_out_valid(satOutValid), .i_out_ready(outReady), .o_out_data(satOutData),
      .o_word_err(satWordErr), .o_frame_last(satFrameLast), .o_frame_err(satFrameErr),
      .o_err_count(satCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] d, input logic p, input logic odd, input logic clr);
      inValid = 1'b1;
      inData  = d;
      inPar   = p;
      oddMode = odd;
      clearIn = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycle();
      inValid = 1'b0;
      clearIn = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic checkBeat(input string name, input logic [7:0] d, input logic we,
                            input logic last, input logic fe, input int cnt);
      checkOutput({name, "_valid"}, 32'(outValid), 32'd1);
      checkOutput({name, "_data"}, 32'(outData), 32'(d));
      checkOutput({name, "_wordErr"}, 32'(wordErr), 32'(we));
      checkOutput({name, "_last"}, 32'(frameLast), 32'(last));
      checkOutput({name, "_frameErr"}, 32'(frameErr), 32'(fe));
      checkOutput({name, "_count"}, 32'(errCount), 32'(cnt));
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, "_valid"}, 32'(outValid), 32'd0);
      checkOutput({name, "_data"}, 32'(outData), 32'd0);
      checkOutput({name, "_wordErr"}, 32'(wordErr), 32'd0);
      checkOutput({name, "_last"}, 32'(frameLast), 32'd0);
      checkOutput({name, "_frameErr"}, 32'(frameErr), 32'd0);
      checkOutput({name, "_count"}, 32'(errCount), 32'd0);
      checkOutput({name, "_satCount"}, 32'(satCount), 32'd0);
   endtask

   initial begin
      // Even frame, odd frame with good LRC, odd frame with bad LRC, even frame with a row error.
      vecs[0]  = '{8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      vecs[1]  = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      vecs[2]  = '{8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      vecs[3]  = '{8'h3E, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
      vecs[4]  = '{8'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
      vecs[5]  = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
      vecs[6]  = '{8'h30, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
      vecs[7]  = '{8'hC1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
      vecs[8]  = '{8'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
      vecs[9]  = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
      vecs[10] = '{8'h30, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
      vecs[11] = '{8'h3E, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1};
      vecs[12] = '{8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      vecs[13] = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      vecs[14] = '{8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      vecs[15] = '{8'h3E, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2};

      rstN = 1'b0; oddMode = 1'b0; clearIn = 1'b0; inValid = 1'b0;
      inData = 8'h00; inPar = 1'b0; outReady = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkAllZero("reset");
      checkOutput("reset_inReady", 32'(inReady), 32'd1);
      rstN = 1'b1;

      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i].data, vecs[i].par, vecs[i].odd, 1'b0);
         checkBeat($sformatf("tbl%0d", i), vecs[i].data, vecs[i].expWordErr,
                   vecs[i].expLast, vecs[i].expFrameErr, vecs[i].expCount);
         checkOutput($sformatf("tbl%0d_satCount", i), 32'(satCount),
                     32'((vecs[i].expCount > 3) ? 3 : vecs[i].expCount));
      end
      idleCycle();
      checkOutput("drain_valid", 32'(outValid), 32'd0);

      // Stall the output for three cycles after the first beat.
      outReady = 1'b0;
      applyStimulus(8'h0F, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
         checkOutput($sformatf("bp%0d_inReady", k), 32'(inReady), 32'd0);
         checkOutput($sformatf("bp%0d_valid", k), 32'(outValid), 32'd1);
         checkOutput($sformatf("bp%0d_data", k), 32'(outData), 32'h0F);
      end
      outReady = 1'b1;
      #1;
      checkOutput("bp_release_inReady", 32'(inReady), 32'd1);
      @(posedge clk);
      #1;
      checkBeat("bp_b1", 8'h01, 1'b0, 1'b0, 1'b0, 2);
      applyStimulus(8'h30, 1'b0, 1'b0, 1'b0);
      checkBeat("bp_b2", 8'h30, 1'b0, 1'b0, 1'b0, 2);
      applyStimulus(8'h3E, 1'b1, 1'b0, 1'b0);
      checkBeat("bp_b3", 8'h3E, 1'b0, 1'b1, 1'b0, 2);
      idleCycle();

      // Clear after two beats restarts the frame; the mid-frame odd_mode toggle is ignored.
      applyStimulus(8'h0F, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h0F, 1'b0, 1'b0, 1'b1);
      checkBeat("clr_b0", 8'h0F, 1'b0, 1'b0, 1'b0, 2);
      applyStimulus(8'h01, 1'b1, 1'b1, 1'b0);
      checkBeat("clr_b1", 8'h01, 1'b0, 1'b0, 1'b0, 2);
      applyStimulus(8'h30, 1'b0, 1'b1, 1'b0);
      checkBeat("clr_b2", 8'h30, 1'b0, 1'b0, 1'b0, 2);
      applyStimulus(8'h3E, 1'b1, 1'b0, 1'b0);
      checkBeat("clr_b3", 8'h3E, 1'b0, 1'b1, 1'b0, 2);
      idleCycle();

      // Reset in the middle of a frame, then a clean frame from beat 0.
      applyStimulus(8'h0F, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
      rstN = 1'b0;
      idleCycle();
      checkAllZero("midRst");
      rstN = 1'b1;
      applyStimulus(8'h0F, 1'b0, 1'b0, 1'b0);
      checkBeat("post_b0", 8'h0F, 1'b0, 1'b0, 1'b0, 0);
      applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h30, 1'b0, 1'b0, 1'b0);
      checkBeat("post_b2", 8'h30, 1'b0, 1'b0, 1'b0, 0);
      applyStimulus(8'h3E, 1'b1, 1'b0, 1'b0);
      checkBeat("post_b3", 8'h3E, 1'b0, 1'b1, 1'b0, 0);

      // Five frames with a bad LRC: the 2-bit counter must stop at 3.
      for (int f = 1; f <= 5; f++) begin
         applyStimulus(8'h0F, 1'b0, 1'b0, 1'b0);
         applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
         applyStimulus(8'h30, 1'b0, 1'b0, 1'b0);
         applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
         checkBeat($sformatf("sat%0d", f), 8'h00, 1'b0, 1'b1, 1'b1, f);
         checkOutput($sformatf("sat%0d_satFrameErr", f), 32'(satFrameErr), 32'd1);
         checkOutput($sformatf("sat%0d_satCount", f), 32'(satCount), 32'((f > 3) ? 3 : f));
      end
      idleCycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
